// File: rtl/nor_decoder_pkg.sv
// Shared constants for the decoder-based NOR primitive: decoder line indices
// and line count.
package nor_decoder_pkg;

   localparam int DEC_LINES = 4;

   localparam int unsigned DEC_00 = 0;
   localparam int unsigned DEC_01 = 1;
   localparam int unsigned DEC_10 = 2;
   localparam int unsigned DEC_11 = 3;

   localparam logic [DEC_LINES-1:0] DEC_IDLE = {DEC_LINES{1'b0}};

endpackage

// File: rtl/decoder_2to4.sv
// 2-to-4 line decoder with enable. The output is one-hot while enabled and
// all-zero while disabled.
module decoder_2to4
   import nor_decoder_pkg::*;
(
   input  logic [1:0]           sel,
   input  logic                 en,
   output logic [DEC_LINES-1:0] y
);

   // Minterm selection; an unknown select or a low enable gives the idle pattern
   always_comb begin
      y = DEC_IDLE;
      if (en) begin
         case (sel)
            2'b00:   y[DEC_00] = 1'b1;
            2'b01:   y[DEC_01] = 1'b1;
            2'b10:   y[DEC_10] = 1'b1;
            2'b11:   y[DEC_11] = 1'b1;
            default: y = DEC_IDLE;
         endcase
      end else begin
         y = DEC_IDLE;
      end
   end

endmodule

// File: rtl/nor_decoder_unit.sv
// Bitwise NOR built from per-lane 2-to-4 decoders. The NOR result is the "00"
// minterm line, and the output stage is optional and valid-qualified.
module nor_decoder_unit
   import nor_decoder_pkg::*;
#(
   parameter int WIDTH   = 1,
   parameter bit REG_OUT = 1'b1
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           a,
   input  logic [WIDTH-1:0]           b,
   input  logic                       in_valid,
   output logic [WIDTH-1:0]           nor_o,
   output logic [DEC_LINES*WIDTH-1:0] dec_o,
   output logic                       out_valid
);

   logic [DEC_LINES*WIDTH-1:0] dec_s;
   logic [WIDTH-1:0]           nor_s;

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      decoder_2to4 u_dec (
         .sel ({a[i], b[i]}),
         .en  (1'b1),
         .y   (dec_s[DEC_LINES*i +: DEC_LINES])
      );
      // NOR is taken directly from the decoder's "00" line, never recomputed
      assign nor_s[i] = dec_s[DEC_LINES*i + DEC_00];
   end

   if (REG_OUT) begin : g_reg
      logic [DEC_LINES*WIDTH-1:0] dec_r;
      logic [WIDTH-1:0]           nor_r;
      logic                       valid_r;

      // Output stage: capture only on valid input, so idle cycles hold the last result
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dec_r   <= {(DEC_LINES*WIDTH){1'b0}};
            nor_r   <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
         end else begin
            valid_r <= in_valid;
            if (in_valid) begin
               dec_r <= dec_s;
               nor_r <= nor_s;
            end
         end
      end

      assign dec_o     = dec_r;
      assign nor_o     = nor_r;
      assign out_valid = valid_r;
   end else begin : g_comb
      assign dec_o     = dec_s;
      assign nor_o     = nor_s;
      assign out_valid = in_valid;
   end

endmodule

// File: tb/tb_nor_decoder_unit.sv
// Directed bench for nor_decoder_unit: registered single-lane and four-lane
// instances plus a combinational two-lane instance.
module tb_nor_decoder_unit;

   logic clk;
   logic rst_n;

   logic        a1, b1, v1;
   logic        nor1;
   logic [3:0]  dec1;
   logic        ov1;

   logic [3:0]  a4, b4;
   logic        v4;
   logic [3:0]  nor4;
   logic [15:0] dec4;
   logic        ov4;

   logic [1:0]  ac, bc;
   logic        vc;
   logic [1:0]  norc;
   logic [7:0]  decc;
   logic        ovc;

   int vecs;
   int misc;

   nor_decoder_unit #(.WIDTH(1), .REG_OUT(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1),
      .nor_o(nor1), .dec_o(dec1), .out_valid(ov1)
   );

   nor_decoder_unit #(.WIDTH(4), .REG_OUT(1'b1)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(v4),
      .nor_o(nor4), .dec_o(dec4), .out_valid(ov4)
   );

   nor_decoder_unit #(.WIDTH(2), .REG_OUT(1'b0)) u_dutc (
      .clk(clk), .rst_n(rst_n), .a(ac), .b(bc), .in_valid(vc),
      .nor_o(norc), .dec_o(decc), .out_valid(ovc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      a1 = 1'b0; b1 = 1'b0; v1 = 1'b1;
      rst_n = 1'b0;
      #1;
      vecs++; if (nor1 !== 1'b0)  begin misc++; $display("FAIL reset_async_nor: got %b expected 0", nor1); end
      vecs++; if (dec1 !== 4'b0)  begin misc++; $display("FAIL reset_async_dec: got %b expected 0000", dec1); end
      vecs++; if (ov1 !== 1'b0)   begin misc++; $display("FAIL reset_async_valid: got %b expected 0", ov1); end
      @(negedge clk);
      vecs++; if ({nor1, dec1, ov1} !== 6'b0) begin misc++; $display("FAIL reset_held: got %b expected 000000", {nor1, dec1, ov1}); end
      vecs++; if ({nor4, dec4, ov4} !== 21'b0) begin misc++; $display("FAIL reset_lane4: got %h expected 0", {nor4, dec4, ov4}); end
      v1 = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_truth_table();
      logic [3:0] exp_dec;
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         if (k > 0) begin
            exp_dec = 4'b0001 << (k - 1);
            vecs++; if (nor1 !== (k == 1)) begin misc++; $display("FAIL tt_nor[%0d]: got %b expected %b", k-1, nor1, (k == 1)); end
            vecs++; if (dec1 !== exp_dec) begin misc++; $display("FAIL tt_dec[%0d]: got %b expected %b", k-1, dec1, exp_dec); end
            vecs++; if (ov1 !== 1'b1) begin misc++; $display("FAIL tt_valid[%0d]: got %b expected 1", k-1, ov1); end
         end
         if (k < 4) begin
            a1 = (k >= 2); b1 = (k % 2 == 1); v1 = 1'b1;
         end else begin
            v1 = 1'b0;
         end
      end
   endtask

   task automatic test_hold();
      @(negedge clk);
      a1 = 1'b0; b1 = 1'b0; v1 = 1'b1;
      @(negedge clk);
      vecs++; if ({nor1, dec1, ov1} !== 6'b1_0001_1) begin misc++; $display("FAIL hold_load: got %b expected 100011", {nor1, dec1, ov1}); end
      a1 = 1'b1; b1 = 1'b1; v1 = 1'b0;
      @(negedge clk);
      vecs++; if ({nor1, dec1, ov1} !== 6'b1_0001_0) begin misc++; $display("FAIL hold_idle: got %b expected 100010", {nor1, dec1, ov1}); end
      a1 = 1'bx; b1 = 1'bz;
      @(negedge clk);
      vecs++; if ({nor1, dec1, ov1} !== 6'b1_0001_0) begin misc++; $display("FAIL hold_xz: got %b expected 100010", {nor1, dec1, ov1}); end
      a1 = 1'b0; b1 = 1'b0;
   endtask

   task automatic test_multi_lane();
      @(negedge clk);
      a4 = 4'b0011; b4 = 4'b0101; v4 = 1'b1;
      @(negedge clk);
      vecs++; if (nor4 !== 4'b1000) begin misc++; $display("FAIL ml_nor_a: got %b expected 1000", nor4); end
      vecs++; if (dec4 !== 16'b0001_0010_0100_1000) begin misc++; $display("FAIL ml_dec_a: got %b expected 0001001001001000", dec4); end
      vecs++; if (ov4 !== 1'b1) begin misc++; $display("FAIL ml_valid_a: got %b expected 1", ov4); end
      a4 = 4'b1111; b4 = 4'b0000;
      @(negedge clk);
      vecs++; if ({nor4, dec4} !== {4'b0000, 16'h4444}) begin misc++; $display("FAIL ml_b: got %h expected 04444", {nor4, dec4}); end
      a4 = 4'b0000; b4 = 4'b0000;
      @(negedge clk);
      vecs++; if ({nor4, dec4} !== {4'b1111, 16'h1111}) begin misc++; $display("FAIL ml_c: got %h expected f1111", {nor4, dec4}); end
      v4 = 1'b0;
      @(negedge clk);
      vecs++; if (ov4 !== 1'b0) begin misc++; $display("FAIL ml_valid_drop: got %b expected 0", ov4); end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      a1 = 1'b0; b1 = 1'b0; v1 = 1'b1;
      @(negedge clk);
      vecs++; if ({nor1, ov1} !== 2'b11) begin misc++; $display("FAIL mr_first: got %b expected 11", {nor1, ov1}); end
      a1 = 1'b1; b1 = 1'b1;
      @(negedge clk);
      vecs++; if ({nor1, dec1} !== 5'b0_1000) begin misc++; $display("FAIL mr_second: got %b expected 01000", {nor1, dec1}); end
      a1 = 1'b0; b1 = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      vecs++; if ({nor1, dec1, ov1} !== 6'b0) begin misc++; $display("FAIL mr_flush: got %b expected 000000", {nor1, dec1, ov1}); end
      #1 rst_n = 1'b1;
      @(negedge clk);
      vecs++; if ({nor1, dec1, ov1} !== 6'b1_0001_1) begin misc++; $display("FAIL mr_recover: got %b expected 100011", {nor1, dec1, ov1}); end
      v1 = 1'b0;
   endtask

   task automatic test_comb();
      logic [1:0] exp_nor;
      logic [7:0] exp_dec;
      logic [1:0] idx;
      vc = 1'b1;
      for (int k = 0; k < 16; k++) begin
         ac = k[3:2]; bc = k[1:0];
         #1;
         exp_nor = ~(ac | bc);
         exp_dec = 8'b0;
         for (int l = 0; l < 2; l++) begin
            idx = {ac[l], bc[l]};
            exp_dec[4*l + idx] = 1'b1;
         end
         vecs++; if ({norc, decc, ovc} !== {exp_nor, exp_dec, 1'b1}) begin
            misc++; $display("FAIL comb[%0d]: got %b expected %b", k, {norc, decc, ovc}, {exp_nor, exp_dec, 1'b1});
         end
      end
      vc = 1'b0;
      #1;
      vecs++; if (ovc !== 1'b0) begin misc++; $display("FAIL comb_valid_low: got %b expected 0", ovc); end
   endtask

   initial begin
      vecs = 0; misc = 0;
      rst_n = 1'b1;
      a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
      a4 = 4'b0; b4 = 4'b0; v4 = 1'b0;
      ac = 2'b0; bc = 2'b0; vc = 1'b0;
      test_reset();
      test_truth_table();
      test_hold();
      test_multi_lane();
      test_mid_reset();
      test_comb();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, misc);
      $finish;
   end

endmodule

// File: doc/nor_decoder_unit.md
Name: nor_decoder_unit

Overview:
- Implements a 2-input NOR using a 2-to-4 line decoder: the output is the decoder's "00" minterm line.
- The operation is bitwise across a parameterised vector width, with a registered output stage and a valid qualifier.
- Used as a universal-gate building block in the logic-primitives group; it feeds downstream logic that samples nor_o on out_valid.

Parameters:
- WIDTH, 1, number of independent bit lanes; a, b and nor_o are WIDTH bits each.
- REG_OUT, 1, 1 = registered outputs with 1-cycle latency; 0 = combinational outputs (out_valid = in_valid).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A, per lane; the decoder MSB select.
- b  input  WIDTH  operand B, per lane; the decoder LSB select.
- in_valid  input  1  qualifies a and b in the current cycle.
- nor_o  output  WIDTH  per-lane ~(a|b), taken from decoder line 0.
- dec_o  output  4*WIDTH  full decoder outputs; lane i occupies bits [4i+3:4i], where bit 4i+k is high iff {a[i],b[i]} == k.
- out_valid  output  1  qualifies nor_o and dec_o.

Behaviour:
- Per lane i, the decoder lines are:
  - d0 = ~a&~b
  - d1 = ~a&b
  - d2 = a&~b
  - d3 = a&b
- Exactly one line per lane is high (one-hot).
- nor_o[i] = d0 of lane i. No other gate may compute nor_o; it must come from the decoder.
- Lanes are fully independent, with no cross-lane interaction.
- REG_OUT=1:
  - When in_valid=1 on a rising clk edge, dec_o and nor_o update from that cycle's a and b.
  - out_valid = registered in_valid, giving 1-cycle latency.
  - When in_valid=0, dec_o and nor_o hold their last values; out_valid drops to 0 the next edge.
  - Back-to-back valid inputs give back-to-back valid outputs at full throughput, with no stalls.
- REG_OUT=0:
  - Outputs are purely combinational from a and b; out_valid = in_valid; clk and rst_n are unused.
- Reset (rst_n=0, asynchronous, effective immediately regardless of clk):
  - nor_o = 0, dec_o = 0 (all lines low, a deliberate non-one-hot idle state), out_valid = 0.
- Release of rst_n is synchronous to the next clk edge. The first edge with rst_n=1 and in_valid=1 captures data normally.
- Reset asserted mid-stream discards any in-flight result; out_valid is 0 until a new valid input is captured.
- X or Z on a or b while in_valid=0 must not disturb held outputs.

Decomposition:
- Shared package nor_decoder_pkg holds:
  - Line-index constants DEC_00=0, DEC_01=1, DEC_10=2, DEC_11=3.
  - The localparam DEC_LINES=4.
- Sub-module decoder_2to4, instantiated once per lane via a generate loop:
  - Inputs sel[1:0] = {a,b} and en.
  - Output y[3:0], one-hot when en=1 and all-zero when en=0.
  - nor_decoder_unit ties en=1 and implements the output register and valid pipeline itself.

Test Plan:
- Reset: assert rst_n=0 while a=0 and b=0 with in_valid=1 -> nor_o=0, dec_o=0, out_valid=0 throughout reset, with no clock edge required.
- Truth table, WIDTH=1, REG_OUT=1: apply {a,b} = 00, 01, 10, 11 on consecutive valid cycles -> one cycle later:
  - nor_o = 1, 0, 0, 0
  - dec_o = 0001, 0010, 0100, 1000
  - out_valid = 1 on each cycle.
- Hold: {a,b}=00 valid, then in_valid=0 with a=1, b=1 -> nor_o stays 1, dec_o stays 0001, out_valid=0 from the second output cycle.
- Multi-lane, WIDTH=4: a=4'b0011, b=4'b0101 valid -> nor_o=4'b1000, dec_o lane0=1000, lane1=0100, lane2=0010, lane3=0001.
- Mid-stream reset: stream 00, 11, 00 with rst_n pulsed low between the 2nd and 3rd edges -> out_valid=0 immediately, then the first post-reset valid input yields nor_o after 1 cycle.
- Combinational, REG_OUT=0: sweep a and b with in_valid=1 -> nor_o tracks ~(a|b) in the same delta cycle, out_valid=1.
